// File: rtl/rfkit_uart_pkg.sv
// rtl/rfkit_uart_pkg.sv - shared UART transmit types and constants
package rfkit_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WAIT_DATA,
        START,
        DATA,
        STOP
    } uart_tx_state_e;

    localparam int   UartDataBits = 8;
    localparam logic TxIdleLevel  = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit clock divider with synchronous clear and bit_done strobe
module uart_bit_timer #(
    parameter int ClocksPerBit = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam int CntW = (ClocksPerBit > 1) ? $clog2(ClocksPerBit) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(ClocksPerBit - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    assign bit_done = !clear && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || bit_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ring_buffer_uart_tx.sv
// rtl/ring_buffer_uart_tx.sv - drains a ring buffer read port into UART 8N1/8N2 frames
module ring_buffer_uart_tx
    import rfkit_uart_pkg::*;
#(
    parameter int ClocksPerBit = 868,
    parameter int StopBits     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       buffer_empty,
    input  logic [7:0] buffer_data,
    input  logic       buffer_data_valid,
    output logic       get,
    output logic       tx,
    output logic       busy,
    output logic       read_error
);

    if (StopBits != 1 && StopBits != 2) begin : g_bad_stop_bits
        $error("StopBits must be 1 or 2");
    end

    localparam logic [2:0] LastBit  = 3'(UartDataBits - 1);
    localparam logic       LastStop = 1'(StopBits - 1);

    uart_tx_state_e state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic           stop_cnt_q, stop_cnt_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           read_error_q, read_error_d;
    logic           timer_clear;
    logic           bit_done;

    // The timer only runs while a frame is on the wire, so START always begins at count 0.
    assign timer_clear = (state_q == IDLE) || (state_q == REQUEST) || (state_q == WAIT_DATA);

    uart_bit_timer #(
        .ClocksPerBit(ClocksPerBit)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .bit_done(bit_done)
    );

    assign get        = (state_q == REQUEST);
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign read_error = read_error_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        stop_cnt_d   = stop_cnt_q;
        tx_d         = tx_q;
        read_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !buffer_empty) begin
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (buffer_data_valid) begin
                    shift_d = buffer_data;
                    tx_d    = 1'b0;
                    state_d = START;
                end else begin
                    read_error_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            START: begin
                if (bit_done) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == LastBit) begin
                        tx_d       = TxIdleLevel;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (stop_cnt_q == LastStop) begin
                        state_d = (enable && !buffer_empty) ? REQUEST : IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = TxIdleLevel;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            stop_cnt_q   <= 1'b0;
            tx_q         <= TxIdleLevel;
            busy_q       <= 1'b0;
            read_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            stop_cnt_q   <= stop_cnt_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            read_error_q <= read_error_d;
        end
    end

endmodule

// File: tb/tb_ring_buffer_uart_tx.sv
// tb/tb_ring_buffer_uart_tx.sv - scoreboard bench for ring_buffer_uart_tx with a ring buffer source model
module tb_ring_buffer_uart_tx;

    localparam int Cpb = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic buf_empty, buf_valid;
    logic [7:0] buf_data;
    logic get, tx, busy, read_error;
    logic buf_empty2, buf_valid2;
    logic get2, tx2, busy2, read_error2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int puts_total = 0, gets_total = 0;
    int puts2 = 0, gets2 = 0;
    int get_cnt = 0, rerr_cnt = 0;
    int frames_done = 0;
    int last_stop_cyc = 0;
    int viol, g0, hi_cnt;
    bit force_invalid = 1'b0;
    logic [7:0] mem [0:63];
    logic [7:0] exp_q[$];
    int gaps[$];
    logic mon_prev = 1'b1;
    logic mon_ok, mon_abort;
    logic [7:0] mon_b, b2;

    always #5 clk = ~clk;

    ring_buffer_uart_tx #(.ClocksPerBit(Cpb), .StopBits(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .buffer_empty(buf_empty),
        .buffer_data(buf_data), .buffer_data_valid(buf_valid),
        .get(get), .tx(tx), .busy(busy), .read_error(read_error)
    );

    ring_buffer_uart_tx #(.ClocksPerBit(Cpb), .StopBits(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(1'b1), .buffer_empty(buf_empty2),
        .buffer_data(8'h3C), .buffer_data_valid(buf_valid2),
        .get(get2), .tx(tx2), .busy(busy2), .read_error(read_error2)
    );

    assign buf_empty  = (puts_total == gets_total);
    assign buf_empty2 = (puts2 == gets2);

    // Ring buffer read port: one-cycle latency from get to data_out/data_out_valid.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (get) get_cnt <= get_cnt + 1;
        if (read_error) rerr_cnt <= rerr_cnt + 1;
        if (get && puts_total != gets_total) begin
            buf_data   <= mem[gets_total];
            buf_valid  <= !force_invalid;
            gets_total <= gets_total + 1;
        end else begin
            buf_valid <= 1'b0;
        end
        if (get2 && puts2 != gets2) begin
            buf_valid2 <= 1'b1;
            gets2      <= gets2 + 1;
        end else begin
            buf_valid2 <= 1'b0;
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(logic [7:0] d, bit expect_tx);
        mem[puts_total] = d;
        puts_total++;
        if (expect_tx) exp_q.push_back(d);
    endtask

    task automatic wait_frames(int n, int budget);
        int i = 0;
        while (frames_done < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("wait_frames", frames_done, n);
    endtask

    task automatic wait_get(int n, int budget);
        int i = 0;
        while (get_cnt < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("wait_get", get_cnt, n);
    endtask

    // UART receiver: decodes each frame on tx, checks its shape and pops the expected byte.
    always begin : monitor
        @(negedge clk);
        if (rst_n && mon_prev && !tx) begin
            gaps.push_back(cyc - last_stop_cyc - 1);
            mon_ok    = 1'b1;
            mon_abort = 1'b0;
            mon_b     = '0;
            for (int n = 1; n < 10 * Cpb; n++) begin
                @(negedge clk);
                if (!rst_n) begin
                    mon_abort = 1'b1;
                    break;
                end
                if (n < Cpb) begin
                    if (tx !== 1'b0) mon_ok = 1'b0;
                end else if (n < 9 * Cpb) begin
                    if (n % Cpb == 0) mon_b[n / Cpb - 1] = tx;
                    else if (tx !== mon_b[n / Cpb - 1]) mon_ok = 1'b0;
                end else if (tx !== 1'b1) begin
                    mon_ok = 1'b0;
                end
            end
            if (!mon_abort) begin
                last_stop_cyc = cyc;
                if (exp_q.size() == 0) chk("unexpected_frame", exp_q.size(), 1);
                else chk("frame_byte", mon_b, exp_q.pop_front());
                chk("frame_shape", mon_ok, 1);
                frames_done++;
            end
        end
        mon_prev = tx;
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        put(8'hA5, 1'b1);
        viol = 0;
        repeat (8) begin
            @(negedge clk);
            if (tx !== 1'b1 || get !== 1'b0 || busy !== 1'b0 || read_error !== 1'b0) viol++;
        end
        chk("reset_quiet", viol, 0);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("get_rise", get, 1);
        @(negedge clk);
        chk("get_width", get, 0);
        chk("tx_before_start", tx, 1);
        @(negedge clk);
        chk("tx_fall", tx, 0);
        chk("busy_frame", busy, 1);
        wait_frames(1, 100);
        @(negedge clk);
        chk("busy_after_stop", busy, 0);
        chk("get_count_a5", get_cnt, 1);

        gaps.delete();
        put(8'h01, 1'b1);
        put(8'h02, 1'b1);
        put(8'h03, 1'b1);
        wait_frames(4, 300);
        chk("get_count_three", get_cnt, 4);
        chk("empty_after_three", buf_empty, 1);
        chk("gap_count", gaps.size(), 3);
        if (gaps.size() == 3) begin
            chk("gap_1_2", gaps[1], 2);
            chk("gap_2_3", gaps[2], 2);
        end

        force_invalid = 1'b1;
        put(8'hEE, 1'b0);
        repeat (10) @(negedge clk);
        force_invalid = 1'b0;
        chk("read_error_pulses", rerr_cnt, 1);
        chk("read_error_no_frame", frames_done, 4);
        chk("read_error_tx", tx, 1);
        chk("read_error_idle", busy, 0);

        g0 = get_cnt;
        put(8'h11, 1'b1);
        put(8'h22, 1'b1);
        wait_get(g0 + 1, 20);
        repeat (12) @(negedge clk);
        enable = 1'b0;
        wait_frames(5, 100);
        repeat (20) @(negedge clk);
        chk("disable_no_get", get_cnt, g0 + 1);
        chk("disable_idle", busy, 0);
        chk("disable_pending", buf_empty, 0);
        enable = 1'b1;
        wait_frames(6, 100);
        chk("reenable_get", get_cnt, g0 + 2);

        g0 = get_cnt;
        put(8'h5A, 1'b1);
        put(8'hC3, 1'b1);
        wait_get(g0 + 1, 20);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_tx_immediate", tx, 1);
        void'(exp_q.pop_front());
        repeat (3) @(negedge clk);
        chk("reset_mid_busy", busy, 0);
        rst_n = 1'b1;
        wait_frames(7, 100);
        chk("after_reset_get", get_cnt, g0 + 2);
        chk("scoreboard_drained", exp_q.size(), 0);

        puts2 = 1;
        for (int i = 0; i < 20 && tx2 !== 1'b0; i++) @(negedge clk);
        chk("stop2_start", tx2, 0);
        hi_cnt = 0;
        b2 = '0;
        for (int n = 1; n <= 11 * Cpb; n++) begin
            @(negedge clk);
            if (n >= Cpb && n < 9 * Cpb && n % Cpb == 0) b2[n / Cpb - 1] = tx2;
            if (n >= 9 * Cpb && n < 11 * Cpb && tx2 === 1'b1 && busy2 === 1'b1) hi_cnt++;
        end
        chk("stop2_byte", b2, 8'h3C);
        chk("stop2_high_cycles", hi_cnt, 2 * Cpb);
        chk("stop2_busy_drop", busy2, 0);
        chk("stop2_tx_idle", tx2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
